// File: rtl/grf_scoreboard.sv
// grf_scoreboard: per-register hazard scoreboard for the 32-entry GRF.
// Tracks in-flight GRF writes from issue to writeback commit, and raises
// stall on unready sources or a saturated destination write count.
// Optional feature macro: GRF_SB_STALL_CNT_EN (builds the stall cycle counter).
module grf_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs,
    input  logic             issue_rs_use,
    input  logic [4:0]       issue_rt,
    input  logic             issue_rt_use,
    input  logic             issue_we,
    input  logic [4:0]       issue_rd,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic             retire_valid,
    input  logic [4:0]       retire_rd,
    output logic             stall,
    output logic [NREG-1:0]  busy_mask,
    output logic             err_underflow,
    output logic [31:0]      stall_cycles
);

    // Register 0 has no storage at all, so it reads as constant zero.
    logic [CNT_W-1:0] pend_cnt [1:NREG-1];
    logic [LAT_W-1:0] ready_cd [1:NREG-1];

    logic src_a_busy;
    logic src_b_busy;
    logic rd_full;
    logic retire_same_rd;
    logic accept;
    logic wr_en;

    // Hazard lookup against pre-update state; index 0 never matches.
    always_comb begin
        src_a_busy = 1'b0;
        src_b_busy = 1'b0;
        rd_full    = 1'b0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (issue_rs == 5'(i) && ready_cd[i] != '0) src_a_busy = 1'b1;
            if (issue_rt == 5'(i) && ready_cd[i] != '0) src_b_busy = 1'b1;
            if (issue_rd == 5'(i) && pend_cnt[i] == '1) rd_full    = 1'b1;
        end
    end

    // Stall decision and accept qualification.
    always_comb begin
        retire_same_rd = retire_valid && (retire_rd == issue_rd);
        stall = issue_valid &&
                ((issue_rs_use && src_a_busy) ||
                 (issue_rt_use && src_b_busy) ||
                 (issue_we && rd_full && !retire_same_rd));
        accept = issue_valid && !stall;
        wr_en  = accept && issue_we && (issue_rd != 5'd0);
    end

    // Per-register pending counts and ready countdowns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                pend_cnt[i] <= '0;
                ready_cd[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (wr_en && issue_rd == 5'(i)) begin
                    ready_cd[i] <= issue_lat;
                end else if (ready_cd[i] != '0) begin
                    ready_cd[i] <= ready_cd[i] - 1'b1;
                end

                // A same-cycle write and retire cancel; a retire against zero is dropped.
                if (wr_en && issue_rd == 5'(i)) begin
                    if (!(retire_valid && retire_rd == 5'(i)))
                        pend_cnt[i] <= pend_cnt[i] + 1'b1;
                end else if (retire_valid && retire_rd == 5'(i) && pend_cnt[i] != '0) begin
                    pend_cnt[i] <= pend_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Sticky underflow flag: retire of a register with nothing in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_underflow <= 1'b0;
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (retire_valid && retire_rd == 5'(i) && pend_cnt[i] == '0)
                    err_underflow <= 1'b1;
            end
        end
    end

    // Busy mask straight from registered pending counts.
    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            busy_mask[i] = (pend_cnt[i] != '0);
        end
    end

`ifdef GRF_SB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Per-register hazard scoreboard for the 32-entry GRF in the pipelined MIPS core.
- Sits beside decode. Tracks in-flight GRF writes from issue to writeback commit.
- Raises `stall` when a source operand's producer is not yet forwardable.
- Also back-pressures issue when a destination's in-flight write count is saturated.

Parameters:
- NREG, 32, number of tracked registers (register 0 is never tracked).
- CNT_W, 2, width of the per-register in-flight write counter; max in-flight = 2^CNT_W-1.
- LAT_W, 3, width of the issue latency field and the per-register ready countdown.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- issue_valid  input  1  decode presents an instruction this cycle.
- issue_rs  input  5  source register A.
- issue_rs_use  input  1  instruction reads rs in this stage.
- issue_rt  input  5  source register B.
- issue_rt_use  input  1  instruction reads rt in this stage.
- issue_we  input  1  instruction writes GRF.
- issue_rd  input  5  destination register.
- issue_lat  input  LAT_W  cycles after acceptance until the result is forwardable (0 = next cycle).
- retire_valid  input  1  a GRF write commits this cycle (writeback).
- retire_rd  input  5  committed destination.
- stall  output  1  combinational; issue not accepted this cycle.
- busy_mask  output  NREG  bit i = register i has at least one uncommitted write.
- err_underflow  output  1  sticky; a retire arrived for a register with zero in-flight writes.
- stall_cycles  output  32  stall counter (see Optional Feature).

Behaviour:
- State per register i (1..31):
  - pend_cnt[i] (CNT_W bits).
  - ready_cd[i] (LAT_W bits).
  - Register 0 state is constant zero and is never written.
- Reset (reset==0, asynchronous):
  - All pend_cnt and ready_cd clear to 0.
  - err_underflow=0, stall_cycles=0, busy_mask=0.
- Stall conditions (combinational, all gated by issue_valid). `stall` is 1 if any holds:
  - (a) issue_rs_use && issue_rs!=0 && ready_cd[issue_rs]!=0.
  - (b) issue_rt_use && issue_rt!=0 && ready_cd[issue_rt]!=0.
  - (c) issue_we && issue_rd!=0 && pend_cnt[issue_rd]==max && !(retire_valid && retire_rd==issue_rd).
  - Otherwise stall=0.
  - When issue_valid=0, stall=0.
- Accept = issue_valid && !stall.
- On accept with issue_we && issue_rd!=0:
  - pend_cnt[rd] increments.
  - ready_cd[rd] loads issue_lat; the youngest producer overwrites any older countdown.
- Sources are checked against pre-update state. An instruction whose rd equals its own rs/rt never stalls on itself.
- Every cycle, each ready_cd not being loaded decrements by 1, saturating at 0.
  - Latency L therefore blocks consumers for exactly L cycles after the accept edge.
- On retire_valid && retire_rd!=0:
  - pend_cnt[retire_rd] decrements.
  - If it is already 0: no change, and err_underflow sets and holds until reset.
- Simultaneous accept-write and retire on the same rd: pend_cnt unchanged; ready_cd still loads issue_lat.
- retire_rd==0 or issue_rd==0 is ignored entirely.
- busy_mask is registered-state derived: busy_mask[i] = (pend_cnt[i]!=0). Bit 0 is always 0.
- Reset asserted mid-operation discards all tracking. The first cycle after release behaves as empty.

Optional Feature:
- Macro: GRF_SB_STALL_CNT_EN.
- Defined: stall_cycles increments by 1 on every clk edge where stall==1, and saturates at 32'hFFFF_FFFF.
- Undefined: no counter logic is built; stall_cycles is constant 0.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset then idle: issue_valid=0 for 5 cycles -> stall=0, busy_mask=0, err_underflow=0.
- Load-use:
  - Accept rd=5, lat=1.
  - Next cycle issue rs=5, rs_use=1 -> stall=1 for 1 cycle, then accepted.
  - busy_mask[5]=1 until retire_rd=5, then 0.
- Latency 0 and $0:
  - Accept rd=8, lat=0, then consumer rs=8 next cycle -> stall=0.
  - Writes/reads to register 0 never stall and never set busy_mask.
- Counter saturation (CNT_W=2):
  - Accept 3 writes to rd=9 with no retire; 4th issue rd=9 -> stall=1.
  - Same cycle retire_rd=9 -> stall=0, pend_cnt stays 3.
- Underflow: retire_rd=12 with nothing pending -> err_underflow=1, stays 1 until reset pulse low, then 0.
- Async reset mid-flight:
  - With rd=3 pending (lat=3), drop reset between clock edges.
  - -> busy_mask=0 immediately.
  - After release, rs=3 consumer -> stall=0.
  - With GRF_SB_STALL_CNT_EN, stall_cycles=0.
